// File: rtl/sine_dac_sequencer.sv
// Full-cycle sine sequencer: phase accumulator, mirrored quarter-wave ROM, segmented DAC encode.
// `define SINE_AMP_SCALE_EN adds the amp_scale port and one scaling stage (latency 3 instead of 2).
module sine_dac_sequencer #(
    parameter int ACC_W   = 16,
    parameter int ADDR_W  = 7,
    parameter int THERM_W = 15,
    parameter int BIN_W   = 3,
    parameter int AMP_W   = 7,
    // ROM_LOAD=0 selects the built-in ramp image (entry i = i); otherwise entry i = ROM_INIT[i*AMP_W +: AMP_W]
    parameter bit ROM_LOAD = 1'b0,
    parameter logic [AMP_W*(2**ADDR_W)-1:0] ROM_INIT = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [ACC_W-1:0]         ftw,
`ifdef SINE_AMP_SCALE_EN
    input  logic [7:0]               amp_scale,
`endif
    output logic [THERM_W+BIN_W-1:0] dac_code,
    output logic                     sign,
    output logic                     code_valid,
    output logic                     busy,
    output logic                     cycle_pulse
);

    localparam int DEPTH = 2**ADDR_W;

    function automatic logic [AMP_W*DEPTH-1:0] rom_image();
        logic [AMP_W*DEPTH-1:0] img;
        img = ROM_INIT;
        if (!ROM_LOAD) begin
            for (int i = 0; i < DEPTH; i++) img[i*AMP_W +: AMP_W] = AMP_W'(i);
        end
        return img;
    endfunction

    localparam logic [AMP_W*DEPTH-1:0] ROM_IMG = rom_image();

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   ftw_q;
    logic [ACC_W:0]     sum;
    logic               wrap;
    logic               first_q;
    logic [1:0]         quad;
    logic [ADDR_W-1:0]  phase_a;
    logic [ADDR_W-1:0]  rom_addr;
`ifdef SINE_AMP_SCALE_EN
    logic [7:0]         scale_q;
`endif

    assign sum      = {1'b0, acc} + {1'b0, ftw_q};
    assign wrap     = sum[ACC_W];
    assign quad     = acc[ACC_W-1 -: 2];
    assign phase_a  = acc[ACC_W-3 -: ADDR_W];
    assign rom_addr = quad[0] ? ~phase_a : phase_a;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            ftw_q   <= '0;
            first_q <= 1'b0;
`ifdef SINE_AMP_SCALE_EN
            scale_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates, so every branch below reads the pre-edge acc/ftw_q/state.
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        acc     <= '0;
                        ftw_q   <= ftw;
                        first_q <= 1'b1;
`ifdef SINE_AMP_SCALE_EN
                        scale_q <= amp_scale;
`endif
                    end
                end
                RUN: begin
                    acc     <= sum[ACC_W-1:0];
                    first_q <= wrap;
                    if (wrap) begin
                        ftw_q   <= ftw;
`ifdef SINE_AMP_SCALE_EN
                        scale_q <= amp_scale;
`endif
                    end
                    if (stop) state <= DRAIN;
                end
                DRAIN: begin
                    acc     <= sum[ACC_W-1:0];
                    first_q <= wrap;
                    // A zero step never wraps, so leave right away.
                    if (wrap || ftw_q == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [AMP_W-1:0] rom_q;
    logic             s1_valid, s1_sign, s1_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_q    <= '0;
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_pulse <= 1'b0;
        end else begin
            rom_q    <= ROM_IMG[int'(rom_addr)*AMP_W +: AMP_W];
            s1_valid <= busy;
            s1_sign  <= quad[1];
            s1_pulse <= busy & first_q;
        end
    end

    logic [AMP_W-1:0] amp;
    logic             amp_valid, amp_sign, amp_pulse;

`ifdef SINE_AMP_SCALE_EN
    logic [AMP_W+7:0] prod;
    logic [AMP_W-1:0] amp_q;
    logic             s2_valid, s2_sign, s2_pulse;

    assign prod = (AMP_W+8)'(rom_q) * (AMP_W+8)'(scale_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            amp_q    <= '0;
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_pulse <= 1'b0;
        end else begin
            amp_q    <= AMP_W'(prod >> 8);
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_pulse <= s1_pulse;
        end
    end

    assign amp       = amp_q;
    assign amp_valid = s2_valid;
    assign amp_sign  = s2_sign;
    assign amp_pulse = s2_pulse;
`else
    assign amp       = rom_q;
    assign amp_valid = s1_valid;
    assign amp_sign  = s1_sign;
    assign amp_pulse = s1_pulse;
`endif

    logic [AMP_W-1:0]   n_seg;
    logic [THERM_W-1:0] therm;

    always_comb begin
        // NOTE: therm gets a full default before the loop, so no path can infer a latch.
        therm = '0;
        n_seg = amp >> BIN_W;
        // i < n_seg saturates at THERM_W on its own: there are only THERM_W segments.
        for (int i = 0; i < THERM_W; i++) therm[i] = (i < int'(n_seg));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_code    <= '0;
            sign        <= 1'b0;
            code_valid  <= 1'b0;
            cycle_pulse <= 1'b0;
        end else begin
            dac_code    <= amp_valid ? {therm, amp[BIN_W-1:0]} : '0;
            sign        <= amp_valid & amp_sign;
            code_valid  <= amp_valid;
            cycle_pulse <= amp_valid & amp_pulse;
        end
    end

endmodule
